// File: rtl/z80_pin_interface_if.sv
// ---------------------------------------------------------------------------
// z80_pin_interface_if
//
// Purpose: groups the internal address bus and the per-cycle latch/enable
// controls that the CPU sequencer drives into the pin interface block.
// The tri-state pins (A, D) and the bidirectional internal data bus (db)
// stay as plain nets on the block itself, because resolved multi-driver
// wires belong at module boundaries rather than inside an interface.
//
// Signals:
//   address        internal address bus (AW bits)
//   ctl_ab_we      load the address latch from address
//   ctl_ab_pin_oe  drive the A pins from the address latch
//   ctl_db_we      load the data latch from db
//   ctl_db_oe      drive db from the data latch
//   ctl_db_pin_re  load the data latch from the D pins
//   ctl_db_pin_oe  drive the D pins from the data latch
//
// Modports:
//   master  sequencer side, drives every signal
//   slave   pin interface side, samples every signal
// ---------------------------------------------------------------------------
interface z80_pin_interface_if #(
  parameter int AW = 16
);

  logic [AW-1:0] address;
  logic          ctl_ab_we;
  logic          ctl_ab_pin_oe;
  logic          ctl_db_we;
  logic          ctl_db_oe;
  logic          ctl_db_pin_re;
  logic          ctl_db_pin_oe;

  modport master (
    output address,
    output ctl_ab_we,
    output ctl_ab_pin_oe,
    output ctl_db_we,
    output ctl_db_oe,
    output ctl_db_pin_re,
    output ctl_db_pin_oe
  );

  modport slave (
    input address,
    input ctl_ab_we,
    input ctl_ab_pin_oe,
    input ctl_db_we,
    input ctl_db_oe,
    input ctl_db_pin_re,
    input ctl_db_pin_oe
  );

endinterface

// File: rtl/z80_pin_interface.sv
// ---------------------------------------------------------------------------
// z80_pin_interface
//
// Purpose: external pin interface of the CPU core. Holds a 16-bit address
// pin latch feeding the A pins and an 8-bit data latch that sits between
// the internal data bus (db) and the D pins. Latch loads happen on the
// rising clock edge; every tri-state enable is purely combinational, so an
// enable change shows on the pins without waiting for a clock edge.
//
// Ports:
//   clk    core clock, all state changes on the rising edge
//   reset  synchronous active-high reset, clears both latches
//   bus    sequencer controls and internal address (slave modport)
//   A      address pins, high-Z unless ctl_ab_pin_oe
//   db     internal bidirectional data bus, driven only when ctl_db_oe
//   D      external data pins, driven only when ctl_db_pin_oe
// ---------------------------------------------------------------------------
module z80_pin_interface #(
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  z80_pin_interface_if.slave    bus,
  output wire  [AW-1:0]         A,
  inout  wire  [DW-1:0]         db,
  inout  wire  [DW-1:0]         D
);

  logic [AW-1:0] ab_latch;
  logic [DW-1:0] db_latch;

  // Address latch: reset wins over a coincident load, otherwise capture
  // the internal address whenever the sequencer asks for it.
  always_ff @(posedge clk) begin
    if (reset) begin
      ab_latch <= '0;
    end else if (bus.ctl_ab_we) begin
      ab_latch <= bus.address;
    end
  end

  // Data latch: a pin read takes priority over an internal write when both
  // are requested in the same cycle. The source buses are sampled exactly
  // as they appear, so a loopback (load while this block is also driving
  // that bus) simply reloads the latch's own value.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_latch <= '0;
    end else if (bus.ctl_db_pin_re) begin
      db_latch <= D;
    end else if (bus.ctl_db_we) begin
      db_latch <= db;
    end
  end

  // Output enables are independent of reset; only the enables decide
  // whether a bus is driven or released.
  assign A  = bus.ctl_ab_pin_oe ? ab_latch : {AW{1'bz}};
  assign db = bus.ctl_db_oe     ? db_latch : {DW{1'bz}};
  assign D  = bus.ctl_db_pin_oe ? db_latch : {DW{1'bz}};

endmodule

// File: tb/tb_z80_pin_interface.sv
// ---------------------------------------------------------------------------
// tb_z80_pin_interface
//
// Purpose: self-checking bench for z80_pin_interface. Every released bus is
// pulled up, so a floating bus reads as all ones. A behavioural model keeps
// the two latch values and works out what each bus must show; a compare
// process checks the DUT against it every falling edge, and a directed
// sequence pins a set of hand-computed values before random traffic runs.
// ---------------------------------------------------------------------------
module tb_z80_pin_interface;

  localparam int AW = 16;
  localparam int DW = 8;

  logic clk;
  logic reset;

  wire [AW-1:0] A;
  wire [DW-1:0] db;
  wire [DW-1:0] D;

  logic          tb_db_en;
  logic [DW-1:0] tb_db;
  logic          tb_d_en;
  logic [DW-1:0] tb_d;

  int test_count;
  int fail_count;
  logic checking;

  logic [AW-1:0] model_a;
  logic [DW-1:0] model_d;

  z80_pin_interface_if #(.AW(AW)) bus_if ();

  z80_pin_interface #(.AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave),
    .A     (A),
    .db    (db),
    .D     (D)
  );

  // The bench only drives db or D while the DUT has that bus released.
  assign db = tb_db_en ? tb_db : {DW{1'bz}};
  assign D  = tb_d_en  ? tb_d  : {DW{1'bz}};

  // Pull-ups make a released bus observable as all ones.
  for (genvar i = 0; i < AW; i++) begin : g_pu_a
    pullup (A[i]);
  end
  for (genvar i = 0; i < DW; i++) begin : g_pu_d
    pullup (D[i]);
    pullup (db[i]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // What a bus carries from the model's point of view.
  function automatic logic [DW-1:0] pinValue();
    if (tb_d_en) return tb_d;
    if (bus_if.ctl_db_pin_oe) return model_d;
    return '1;
  endfunction

  function automatic logic [DW-1:0] dbValue();
    if (tb_db_en) return tb_db;
    if (bus_if.ctl_db_oe) return model_d;
    return '1;
  endfunction

  // Model update on every rising edge, straight from the latch rules.
  always @(posedge clk) begin
    logic [DW-1:0] pin_now;
    logic [DW-1:0] db_now;
    pin_now = pinValue();
    db_now  = dbValue();
    if (reset) begin
      model_a = '0;
      model_d = '0;
    end else begin
      if (bus_if.ctl_ab_we) model_a = bus_if.address;
      if (bus_if.ctl_db_pin_re) model_d = pin_now;
      else if (bus_if.ctl_db_we) model_d = db_now;
    end
  end

  task automatic checkOutput(input string name, input logic [AW-1:0] act,
                             input logic [AW-1:0] exp);
    test_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model; buses the bench is driving
  // itself are skipped.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("cyc_A", A, bus_if.ctl_ab_pin_oe ? model_a : '1);
      if (!tb_db_en)
        checkOutput("cyc_db", {8'h00, db}, {8'h00, bus_if.ctl_db_oe ? model_d : 8'hFF});
      if (!tb_d_en)
        checkOutput("cyc_D", {8'h00, D}, {8'h00, bus_if.ctl_db_pin_oe ? model_d : 8'hFF});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleControls();
    bus_if.ctl_ab_we     = 1'b0;
    bus_if.ctl_ab_pin_oe = 1'b0;
    bus_if.ctl_db_we     = 1'b0;
    bus_if.ctl_db_oe     = 1'b0;
    bus_if.ctl_db_pin_re = 1'b0;
    bus_if.ctl_db_pin_oe = 1'b0;
    tb_db_en = 1'b0;
    tb_d_en  = 1'b0;
  endtask

  // One random cycle, constrained so the bench never fights the DUT and
  // never loads from a floating bus.
  task automatic applyStimulus();
    bus_if.address       = AW'($urandom);
    bus_if.ctl_ab_we     = 1'($urandom);
    bus_if.ctl_ab_pin_oe = 1'($urandom);
    bus_if.ctl_db_oe     = 1'($urandom);
    bus_if.ctl_db_pin_oe = 1'($urandom);
    tb_d_en  = !bus_if.ctl_db_pin_oe && ($urandom_range(0, 1) == 1);
    tb_db_en = !bus_if.ctl_db_oe && ($urandom_range(0, 1) == 1);
    tb_d     = DW'($urandom);
    tb_db    = DW'($urandom);
    bus_if.ctl_db_pin_re = (tb_d_en || bus_if.ctl_db_pin_oe) && ($urandom_range(0, 2) == 0);
    bus_if.ctl_db_we     = (tb_db_en || bus_if.ctl_db_oe) && ($urandom_range(0, 1) == 1);
    reset = ($urandom_range(0, 31) == 0);
    step();
  endtask

  initial begin
    test_count = 0;
    fail_count = 0;
    checking   = 1'b0;
    reset      = 1'b1;
    tb_d  = '0;
    tb_db = '0;
    bus_if.address = '0;
    idleControls();
    step();
    step();
    reset = 1'b0;
    checking = 1'b1;

    // Reset state on enabled outputs.
    bus_if.ctl_ab_pin_oe = 1'b1;
    bus_if.ctl_db_pin_oe = 1'b1;
    #1;
    checkOutput("reset_A", A, 16'h0000);
    checkOutput("reset_D", {8'h00, D}, 16'h0000);
    idleControls();

    // Address load and hold.
    bus_if.address = 16'hAA55;
    bus_if.ctl_ab_we = 1'b1;
    bus_if.ctl_ab_pin_oe = 1'b1;
    step();
    checkOutput("addr_load", A, 16'hAA55);
    bus_if.ctl_ab_we = 1'b0;
    bus_if.address = 16'h1234;
    step();
    checkOutput("addr_hold", A, 16'hAA55);

    // Address tri-state without a clock edge.
    bus_if.ctl_ab_pin_oe = 1'b0;
    #1 checkOutput("addr_z0", A, 16'hFFFF);
    bus_if.ctl_ab_pin_oe = 1'b1;
    #1 checkOutput("addr_on", A, 16'hAA55);
    bus_if.ctl_ab_pin_oe = 1'b0;
    #1 checkOutput("addr_z1", A, 16'hFFFF);

    // Pin read to internal bus.
    tb_d = 8'hAA;
    tb_d_en = 1'b1;
    bus_if.ctl_db_pin_re = 1'b1;
    step();
    idleControls();
    bus_if.ctl_db_oe = 1'b1;
    #1 checkOutput("pin_read_db", {8'h00, db}, 16'h00AA);

    // Internal write to pins.
    idleControls();
    tb_db = 8'h55;
    tb_db_en = 1'b1;
    bus_if.ctl_db_we = 1'b1;
    step();
    idleControls();
    bus_if.ctl_db_pin_oe = 1'b1;
    #1 checkOutput("int_write_D", {8'h00, D}, 16'h0055);
    bus_if.ctl_db_oe = 1'b1;
    #1 checkOutput("int_write_db", {8'h00, db}, 16'h0055);

    // Self-loopback on both sides leaves the latch unchanged.
    bus_if.ctl_db_we = 1'b1;
    step();
    bus_if.ctl_db_we = 1'b0;
    bus_if.ctl_db_pin_re = 1'b1;
    step();
    idleControls();
    bus_if.ctl_db_oe = 1'b1;
    #1 checkOutput("loopback", {8'h00, db}, 16'h0055);

    // Pin read has priority over internal write.
    idleControls();
    tb_d = 8'hF0;
    tb_d_en = 1'b1;
    tb_db = 8'h0F;
    tb_db_en = 1'b1;
    bus_if.ctl_db_pin_re = 1'b1;
    bus_if.ctl_db_we = 1'b1;
    step();
    idleControls();
    bus_if.ctl_db_oe = 1'b1;
    #1 checkOutput("priority", {8'h00, db}, 16'h00F0);

    // Reset beats coincident loads.
    idleControls();
    bus_if.address = 16'hBEEF;
    bus_if.ctl_ab_we = 1'b1;
    tb_db = 8'hC3;
    tb_db_en = 1'b1;
    bus_if.ctl_db_we = 1'b1;
    step();
    bus_if.ctl_ab_pin_oe = 1'b1;
    #1 checkOutput("pre_reset_A", A, 16'hBEEF);
    bus_if.ctl_ab_pin_oe = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    idleControls();
    bus_if.ctl_ab_pin_oe = 1'b1;
    bus_if.ctl_db_pin_oe = 1'b1;
    #1;
    checkOutput("rst_A", A, 16'h0000);
    checkOutput("rst_D", {8'h00, D}, 16'h0000);
    idleControls();
    #1;
    checkOutput("rst_A_z", A, 16'hFFFF);
    checkOutput("rst_D_z", {8'h00, D}, 16'h00FF);
    checkOutput("rst_db_z", {8'h00, db}, 16'h00FF);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      applyStimulus();
    end
    reset = 1'b0;
    idleControls();
    step();
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/z80_pin_interface.md
Name: z80_pin_interface

Overview:
- Combined external pin interface of the CPU core: a 16-bit address pin latch and an 8-bit bidirectional data pin latch.
- Sits between the internal address bus and internal data bus (db) on one side and the package pins A[15:0] and D[7:0] on the other.
- All latch loads are clocked; all tri-state enables are combinational.

Parameters:
- AW, 16, address bus width.
- DW, 8, data bus width.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- address  input  AW  internal address bus.
- ctl_ab_we  input  1  load the address latch from address.
- ctl_ab_pin_oe  input  1  drive A from the address latch; A is high-Z otherwise.
- A  output(tri)  AW  address pins.
- db  inout  DW  internal bidirectional data bus.
- ctl_db_we  input  1  load the data latch from db.
- ctl_db_oe  input  1  drive db from the data latch; db is high-Z otherwise.
- ctl_db_pin_re  input  1  load the data latch from the D pins.
- ctl_db_pin_oe  input  1  drive D from the data latch; D is high-Z otherwise.
- D  inout  DW  external data pins.

Behaviour:
- Address latch (AW-bit register):
  - reset=1 at a rising edge: clears to 0.
  - Else, if ctl_ab_we=1: captures address.
  - Else: holds.
- A = ctl_ab_pin_oe ? address latch : all-Z. Purely combinational, so the enable takes effect without a clock edge.
- Changes on address while ctl_ab_we=0 never affect the latch or A.
- Data latch (DW-bit register), at a rising edge, in priority order:
  - reset=1: clears to 0.
  - Else ctl_db_pin_re=1: captures D.
  - Else ctl_db_we=1: captures db.
  - Else: holds.
- Pin read has priority over internal write when both are asserted in the same cycle.
- db = ctl_db_oe ? data latch : all-Z.
- D = ctl_db_pin_oe ? data latch : all-Z.
- Both output enables are combinational and independent of reset.
- Reset does not force any bus to high-Z; the enables alone control tri-state.
- Self-loopback:
  - ctl_db_we=1 together with ctl_db_oe=1 reloads the latch's own value, so the latch is unchanged.
  - ctl_db_pin_re=1 together with ctl_db_pin_oe=1 behaves the same way.
- Latency:
  - A loaded value is visible on an enabled output after the same rising edge that captures it.
  - Enable changes are visible immediately (zero cycles).
- The two latches are fully independent; there is no shared state.
- Z or X on the sampled source bus during a load is captured as-is. It is the controller's responsibility not to load from a floating bus.
- Reset asserted mid-operation (e.g. coincident with ctl_ab_we or ctl_db_pin_re) wins: the latch clears to 0 that edge.

Test Plan:
- Address load and output: address=16'hAA55, ctl_ab_we=1, ctl_ab_pin_oe=1, one edge -> A=16'hAA55. Then ctl_ab_we=0, address=16'h1234 -> A stays 16'hAA55.
- Address tri-state: ctl_ab_pin_oe toggled 0/1/0 with latch=16'hAA55 -> A alternates 16'hZZZZ / 16'hAA55 / 16'hZZZZ, with no clock edge required.
- Pin read to internal bus:
  - Setup: bench drives D=8'hAA, ctl_db_pin_re=1, ctl_db_pin_oe=0, ctl_db_oe=0; one edge.
  - Then release D and db, set ctl_db_oe=1 -> db=8'hAA.
- Internal write to pins:
  - Setup: bench drives db=8'h55, ctl_db_we=1, ctl_db_oe=0; one edge.
  - Then release db and D, set ctl_db_pin_oe=1 -> D=8'h55.
  - With ctl_db_oe=1 -> db=8'h55.
- Priority: D=8'hF0, db=8'h0F, ctl_db_pin_re=1 and ctl_db_we=1 in the same cycle -> latch=8'hF0 (read back via ctl_db_oe=1).
- Reset: load address 16'hBEEF and data 8'hC3, then reset=1 for one edge with ctl_ab_we=1 and ctl_db_we=1 -> with enables high, A=16'h0000 and D=8'h00. Enables low -> A, D and db all Z.
